// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one combinational ALU with a one-deep response slot
// Optional: define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins), default is round-robin.
module alu_arbiter #(
    parameter int WIDTH   = 16,
    parameter int INSTR_W = 9
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [WIDTH-1:0]   req0_x_i,
    input  logic [WIDTH-1:0]   req0_y_i,
    input  logic [INSTR_W-1:0] req0_instruction_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [WIDTH-1:0]   req1_x_i,
    input  logic [WIDTH-1:0]   req1_y_i,
    input  logic [INSTR_W-1:0] req1_instruction_i,
    output logic [WIDTH-1:0]   alu_x_o,
    output logic [WIDTH-1:0]   alu_y_o,
    output logic [INSTR_W-1:0] alu_instruction_o,
    input  logic [WIDTH-1:0]   alu_out_i,
    input  logic               alu_zr_i,
    input  logic               alu_ng_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [WIDTH-1:0]   rsp_out_o,
    output logic               rsp_zr_o,
    output logic               rsp_ng_o
);

    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic             rsp_zr_q, rsp_zr_d;
    logic             rsp_ng_q, rsp_ng_d;

    logic slot_free;
    logic grant_vld;
    logic grant_id;
    logic accept;

    assign slot_free = !rsp_valid_q || rsp_ready_i;

    // Grant looks only at valids and last, never at payloads.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_vld = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id  = 1'b0;
`else
            grant_id  = ~last_q;
`endif
        end else if (req0_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid_i) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept       = grant_vld && slot_free && !reset_i;
    assign req0_ready_o = accept && !grant_id;
    assign req1_ready_o = accept && grant_id;

    always_comb begin
        alu_x_o           = '0;
        alu_y_o           = '0;
        alu_instruction_o = '0;
        if (grant_vld) begin
            if (grant_id) begin
                alu_x_o           = req1_x_i;
                alu_y_o           = req1_y_i;
                alu_instruction_o = req1_instruction_i;
            end else begin
                alu_x_o           = req0_x_i;
                alu_y_o           = req0_y_i;
                alu_instruction_o = req0_instruction_i;
            end
        end
    end

    // A new accept overwrites a response taken in the same cycle; payload holds when only taken.
    always_comb begin
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_zr_d    = rsp_zr_q;
        rsp_ng_d    = rsp_ng_q;
        if (accept) begin
            last_d      = grant_id;
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_id;
            rsp_out_d   = alu_out_i;
            rsp_zr_d    = alu_zr_i;
            rsp_ng_d    = alu_ng_i;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_out_q   <= '0;
            rsp_zr_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_zr_q    <= rsp_zr_d;
            rsp_ng_q    <= rsp_ng_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_out_o   = rsp_out_q;
    assign rsp_zr_o    = rsp_zr_q;
    assign rsp_ng_o    = rsp_ng_q;

endmodule
